// File: rtl/mux_ctrl_pkg.sv
// rtl/mux_ctrl_pkg.sv - shared types and mux select encoding for the 2:1 mux arbiter
package mux_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2,
        TURN  = 2'd3
    } arb_state_t;

    typedef enum logic {
        SRC_A = 1'b0,
        SRC_B = 1'b1
    } src_t;

    localparam logic SEL_A = 1'b1;
    localparam logic SEL_B = 1'b0;

endpackage

// File: rtl/mux_hold_cnt.sv
// rtl/mux_hold_cnt.sv - saturating up-counter used for hold time and turnaround gap
module mux_hold_cnt #(
    parameter int MAX = 16,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         at_max
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != W'(MAX))) begin
            cnt <= cnt + W'(1);
        end
    end

    assign at_max = (cnt == W'(MAX));

endmodule

// File: rtl/mux2_bus_arbiter.sv
// rtl/mux2_bus_arbiter.sv - round-robin owner sequencer for a shared tri-state 2:1 mux
module mux2_bus_arbiter
    import mux_ctrl_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int TURN_CYC = 1,
    parameter int CNT_W    = $clog2(MAX_HOLD + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic req_a,
    input  logic req_b,
    input  logic done_a,
    input  logic done_b,
    output logic gnt_a,
    output logic gnt_b,
    output logic se,
    output logic en,
    output logic busy
);

    localparam int  TURN_MAX = (TURN_CYC > 0) ? TURN_CYC : 1;
    localparam int  TURN_W   = $clog2(TURN_MAX + 1);
    localparam bit  DIRECT   = (TURN_CYC == 0);

    arb_state_t        r_state;
    arb_state_t        w_next;
    src_t              r_last;
    src_t              r_tgt;
    logic [CNT_W-1:0]  w_hold_cnt;
    logic              w_hold_sat;
    logic [TURN_W-1:0] w_turn_cnt;
    logic              w_turn_sat;
    logic              w_owning;
    logic              w_hold_exp;
    logic              w_turn_exp;
    logic              w_rel_a;
    logic              w_rel_b;
    logic              w_tgt_req;
    logic              w_prev_req;

    assign w_owning   = (r_state == OWN_A) || (r_state == OWN_B);
    // Count reads MAX_HOLD-1 during the MAX_HOLD-th owned cycle; saturation covers late contention.
    assign w_hold_exp = (w_hold_cnt == CNT_W'(MAX_HOLD - 1)) || w_hold_sat;
    assign w_turn_exp = (w_turn_cnt == TURN_W'(TURN_MAX - 1)) || w_turn_sat;

    assign w_rel_a = (r_state == OWN_A) && (done_a || !req_a || (w_hold_exp && req_b));
    assign w_rel_b = (r_state == OWN_B) && (done_b || !req_b || (w_hold_exp && req_a));

    assign w_tgt_req  = (r_tgt == SRC_A) ? req_a : req_b;
    assign w_prev_req = (r_tgt == SRC_A) ? req_b : req_a;

    mux_hold_cnt #(.MAX(MAX_HOLD), .W(CNT_W)) u_hold_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (!w_owning || w_rel_a || w_rel_b),
        .inc    (w_owning),
        .cnt    (w_hold_cnt),
        .at_max (w_hold_sat)
    );

    mux_hold_cnt #(.MAX(TURN_MAX), .W(TURN_W)) u_turn_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (r_state != TURN),
        .inc    (r_state == TURN),
        .cnt    (w_turn_cnt),
        .at_max (w_turn_sat)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (req_a && req_b)  w_next = (r_last == SRC_B) ? OWN_A : OWN_B;
                else if (req_a)      w_next = OWN_A;
                else if (req_b)      w_next = OWN_B;
            end
            OWN_A: begin
                if (w_rel_a) w_next = req_b ? (DIRECT ? OWN_B : TURN) : IDLE;
            end
            OWN_B: begin
                if (w_rel_b) w_next = req_a ? (DIRECT ? OWN_A : TURN) : IDLE;
            end
            TURN: begin
                if (w_turn_exp) begin
                    if (w_tgt_req)       w_next = (r_tgt == SRC_A) ? OWN_A : OWN_B;
                    else if (w_prev_req) w_next = (r_tgt == SRC_A) ? OWN_B : OWN_A;
                    else                 w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_last  <= SRC_B;
            r_tgt   <= SRC_B;
            gnt_a   <= 1'b0;
            gnt_b   <= 1'b0;
            se      <= SEL_B;
            en      <= 1'b0;
            busy    <= 1'b0;
        end else begin
            r_state <= w_next;
            gnt_a   <= (w_next == OWN_A);
            gnt_b   <= (w_next == OWN_B);
            en      <= (w_next == OWN_A) || (w_next == OWN_B);
            busy    <= (w_next != IDLE);
            // se keeps its last value while the mux is disabled
            if (w_next == OWN_A)      se <= SEL_A;
            else if (w_next == OWN_B) se <= SEL_B;
            if (w_rel_a) begin
                r_last <= SRC_A;
                r_tgt  <= SRC_B;
            end else if (w_rel_b) begin
                r_last <= SRC_B;
                r_tgt  <= SRC_A;
            end
        end
    end

endmodule
